// File: rtl/way_feed_arbiter_pkg.sv
// Shared definitions for the way feed arbiter: hold-counter width and the
// helpers that derive way count, block width and packed-slice offsets.
package way_feed_arbiter_pkg;

    // Width of the per-way issue holdoff counter (covers EMP_LAT up to 7).
    localparam int HOLD_W = 3;

    // Number of ways for a given log2 way count.
    function automatic int way_count(input int w_log);
        return 1 << w_log;
    endfunction

    // Bits per block: DATW-bit records, 2^P_LOG of them.
    function automatic int block_width(input int p_log, input int datw);
        return datw << p_log;
    endfunction

    // Low bit of slice idx inside a vector of packed bw-bit slices.
    function automatic int slice_lo(input int idx, input int bw);
        return idx * bw;
    endfunction

endpackage

// File: rtl/way_feed_arbiter_rr_pick.sv
// Rotate-priority encoder: picks the first set request at or after ptr,
// wrapping modulo the way count. Purely combinational.
module way_feed_arbiter_rr_pick
    import way_feed_arbiter_pkg::*;
#(
    parameter int N_LOG = 5
) (
    input  logic [(1<<N_LOG)-1:0] req,
    input  logic [N_LOG-1:0]      ptr,
    output logic [(1<<N_LOG)-1:0] gnt,
    output logic [N_LOG-1:0]      idx,
    output logic                  any
);

    localparam int N = way_count(N_LOG);

    // Duplicating the vector lets a plain part-select implement the rotation.
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N_LOG-1:0] off;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N];

    // Lowest set bit of the rotated vector is the closest request after ptr.
    always_comb begin
        any = 1'b0;
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                any = 1'b1;
                off = k[N_LOG-1:0];
            end
        end
    end

    // Undo the rotation; the W-bit add wraps naturally.
    always_comb begin
        idx = ptr + off;
        gnt = '0;
        if (any) begin
            gnt = {{(N-1){1'b0}}, 1'b1} << idx;
        end
    end

endmodule

// File: rtl/way_feed_arbiter.sv
// Round-robin feeder for the merge-sorter tree input port. Grants one way per
// cycle whose source has a block and whose leaf queue is empty, then issues
// that block to the tree on the next cycle. A per-way holdoff counter masks
// the tree's stale empty flag for EMP_LAT cycles after each issue.
// Optional: define WAY_FEED_CNT_EN to add feed_cnt / stall_cnt counters.
module way_feed_arbiter
    import way_feed_arbiter_pkg::*;
#(
    parameter int W_LOG   = 5,
    parameter int P_LOG   = 3,
    parameter int DATW    = 64,
    parameter int EMP_LAT = 2
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                STALL,
    input  logic [(1<<W_LOG)-1:0]               src_valid,
    input  logic [((DATW<<P_LOG)<<W_LOG)-1:0]   src_data,
    output logic [(1<<W_LOG)-1:0]               src_ready,
    input  logic [(1<<W_LOG)-1:0]               tree_emp,
    output logic [(DATW<<P_LOG)-1:0]            tree_din,
    output logic                                tree_dinen,
    output logic [W_LOG-1:0]                    tree_din_idx
`ifdef WAY_FEED_CNT_EN
    ,
    output logic [31:0]                         feed_cnt,
    output logic [31:0]                         stall_cnt
`endif
);

    localparam int NW = way_count(W_LOG);
    localparam int BW = block_width(P_LOG, DATW);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(EMP_LAT);

    logic [NW-1:0]    eligible;
    logic [NW-1:0]    gnt;
    logic [W_LOG-1:0] gnt_idx;
    logic             gnt_any;
    logic [W_LOG-1:0] ptr_reg;
    logic [BW-1:0]    blk_sel;

    logic [BW-1:0]    tree_din_reg;
    logic             tree_dinen_reg;
    logic [W_LOG-1:0] tree_din_idx_reg;

    // Per-way holdoff counter and eligibility.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_way
            logic [HOLD_W-1:0] hold_reg;

            assign eligible[gi] = src_valid[gi] & tree_emp[gi] & (hold_reg == '0)
                                  & ~STALL & ~RST;

            // Load on grant wins; otherwise count down to zero, even while stalled.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    hold_reg <= '0;
                end else if (gnt[gi]) begin
                    hold_reg <= HOLD_LOAD;
                end else if (hold_reg != '0) begin
                    hold_reg <= hold_reg - 1'b1;
                end
            end
        end
    endgenerate

    way_feed_arbiter_rr_pick #(
        .N_LOG (W_LOG)
    ) u_pick (
        .req (eligible),
        .ptr (ptr_reg),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign src_ready = gnt;
    assign blk_sel   = src_data[slice_lo(int'(gnt_idx), BW) +: BW];

    // Output stage and round-robin pointer; a reset drops any in-flight block.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_reg          <= '0;
            tree_din_reg     <= '0;
            tree_dinen_reg   <= 1'b0;
            tree_din_idx_reg <= '0;
        end else if (gnt_any) begin
            ptr_reg          <= gnt_idx + W_LOG'(1);
            tree_din_reg     <= blk_sel;
            tree_dinen_reg   <= 1'b1;
            tree_din_idx_reg <= gnt_idx;
        end else begin
            tree_dinen_reg   <= 1'b0;
        end
    end

    assign tree_din     = tree_din_reg;
    assign tree_dinen   = tree_dinen_reg;
    assign tree_din_idx = tree_din_idx_reg;

`ifdef WAY_FEED_CNT_EN
    logic [31:0] feed_cnt_reg;
    logic [31:0] stall_cnt_reg;

    // feed_cnt tracks issued blocks; stall_cnt counts cycles STALL blocked real work.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            feed_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (gnt_any) begin
                feed_cnt_reg <= feed_cnt_reg + 32'd1;
            end
            if (STALL && |(src_valid & tree_emp)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign feed_cnt  = feed_cnt_reg;
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_way_feed_arbiter.sv
// Directed bench for way_feed_arbiter with 4 ways, 2-record 16-bit blocks,
// EMP_LAT=2. Expected values are hand-derived for each step.
module tb_way_feed_arbiter;

    localparam int W_LOG   = 2;
    localparam int P_LOG   = 1;
    localparam int DATW    = 16;
    localparam int EMP_LAT = 2;
    localparam int NW      = 1 << W_LOG;
    localparam int BW      = DATW << P_LOG;

    logic              CLK;
    logic              RST;
    logic              STALL;
    logic [NW-1:0]     src_valid;
    logic [BW*NW-1:0]  src_data;
    logic [NW-1:0]     src_ready;
    logic [NW-1:0]     tree_emp;
    logic [BW-1:0]     tree_din;
    logic              tree_dinen;
    logic [W_LOG-1:0]  tree_din_idx;
`ifdef WAY_FEED_CNT_EN
    logic [31:0]       feed_cnt;
    logic [31:0]       stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    way_feed_arbiter #(
        .W_LOG   (W_LOG),
        .P_LOG   (P_LOG),
        .DATW    (DATW),
        .EMP_LAT (EMP_LAT)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .STALL        (STALL),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .tree_emp     (tree_emp),
        .tree_din     (tree_din),
        .tree_dinen   (tree_dinen),
        .tree_din_idx (tree_din_idx)
`ifdef WAY_FEED_CNT_EN
        ,
        .feed_cnt     (feed_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Distinct block content per way.
    function automatic logic [31:0] blk(input int i);
        return {16'hB000 + 16'(i), 16'hC000 + 16'(i)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven after a negedge. Check the combinational
    // grant, then the registered output after the posedge, end at next negedge.
    task automatic step(input string tag, input logic [3:0] er, input bit een,
                        input int ei);
        #1;
        chk({tag, ".ready"}, 32'(src_ready), 32'(er));
        @(posedge CLK);
        #1;
        chk({tag, ".dinen"}, 32'(tree_dinen), 32'(een));
        if (een) begin
            chk({tag, ".idx"}, 32'(tree_din_idx), 32'(ei));
            chk({tag, ".din"}, tree_din, blk(ei));
            $display("%s: ready=%b issued way %0d data %h", tag, er, tree_din_idx, tree_din);
        end else begin
            $display("%s: ready=%b no issue", tag, er);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST       = 1'b1;
        STALL     = 1'b0;
        src_valid = 4'b1111;
        tree_emp  = 4'b1111;
        for (int i = 0; i < NW; i++) src_data[i*BW +: BW] = blk(i);

        // Held in reset with every source valid: nothing may move.
        repeat (4) begin
            @(negedge CLK);
            chk("rst.ready", 32'(src_ready), 32'h0);
            chk("rst.dinen", 32'(tree_dinen), 32'h0);
            chk("rst.idx",   32'(tree_din_idx), 32'h0);
            chk("rst.din",   tree_din, 32'h0);
            $display("reset cycle: ready=%b dinen=%b", src_ready, tree_dinen);
        end
        RST = 1'b0;

        // Plain rotation 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            step("rr", 4'(1 << (k % 4)), 1'b1, k % 4);
        end

        // Stall: no grants, output register keeps last block; resume at ptr=1.
        STALL = 1'b1;
        repeat (3) begin
            step("stall", 4'b0000, 1'b0, 0);
            chk("stall.idx_hold", 32'(tree_din_idx), 32'h0);
            chk("stall.din_hold", tree_din, blk(0));
        end
        STALL = 1'b0;
        step("resume", 4'b0010, 1'b1, 1);

        // Move ptr to 3, then ways 1 and 3: 3 first, wrap to 1, ptr ends at 2.
        src_valid = 4'b0100;
        step("ptr3", 4'b0100, 1'b1, 2);
        src_valid = 4'b1010;
        step("wrap3", 4'b1000, 1'b1, 3);
        step("wrap1", 4'b0010, 1'b1, 1);
        src_valid = 4'b1111;
        step("ptr2", 4'b0100, 1'b1, 2);

        // Full leaf queues block everything (also lets holds drain).
        tree_emp = 4'b0000;
        repeat (3) step("full", 4'b0000, 1'b0, 0);
        tree_emp = 4'b1111;

        // Single way, empty flag stuck high: issues every EMP_LAT+1 cycles.
        src_valid = 4'b0100;
        for (int k = 0; k < 7; k++) begin
            step("hold", (k % 3 == 0) ? 4'b0100 : 4'b0000, k % 3 == 0, 2);
        end

        // Reset while way 1's block is on the tree port.
        src_valid = 4'b0010;
        #1;
        chk("pre_rst.ready", 32'(src_ready), 32'h2);
        @(posedge CLK);
        #1;
        chk("pre_rst.dinen", 32'(tree_dinen), 32'h1);
        chk("pre_rst.idx",   32'(tree_din_idx), 32'h1);
`ifdef WAY_FEED_CNT_EN
        chk("pre_rst.feed_cnt",  feed_cnt, 32'd14);
        chk("pre_rst.stall_cnt", stall_cnt, 32'd3);
`endif
        $display("pre-reset: issued way %0d", tree_din_idx);
        RST = 1'b1;
        #1;
        chk("mid_rst.dinen", 32'(tree_dinen), 32'h0);
        chk("mid_rst.idx",   32'(tree_din_idx), 32'h0);
        chk("mid_rst.din",   tree_din, 32'h0);
        chk("mid_rst.ready", 32'(src_ready), 32'h0);
`ifdef WAY_FEED_CNT_EN
        chk("mid_rst.feed_cnt",  feed_cnt, 32'd0);
        chk("mid_rst.stall_cnt", stall_cnt, 32'd0);
`endif
        $display("mid-reset: dinen=%b idx=%0d", tree_dinen, tree_din_idx);
        @(negedge CLK);
        RST = 1'b0;
        // Way 1's holdoff must be gone, and ptr back at 0.
        src_valid = 4'b0010;
        #1;
        chk("post_rst.hold_clear", 32'(src_ready), 32'h2);
        src_valid = 4'b1111;
        step("post_rst", 4'b0001, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/way_feed_arbiter.md
# way_feed_arbiter

Round-robin scheduler that shares the single input port of the virtual merge sorter tree (din / dinen / din_idx) among 2^W_LOG per-way record sources. Each cycle it grants at most one way whose source holds a block and whose leaf queue in the tree reports empty, then issues that block to the tree one cycle later. It replaces ad-hoc "fill way i when sel==i" loops with a fair, work-conserving arbiter plus per-way issue holdoff covering the tree's empty-flag latency.

## Interface
- W_LOG, 5, log2 of way count (ways = 1<<W_LOG)
- P_LOG, 3, log2 of records per block (block = DATW<<P_LOG bits)
- DATW, 64, record width
- EMP_LAT, 2, cycles tree emp[i] may stay high after a block is issued to way i; legal 1..7
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- STALL  in  1  suppress all new grants this cycle
- src_valid  in  1<<W_LOG  way i source holds a block
- src_data  in  (DATW<<P_LOG)<<W_LOG  packed blocks, way i at slice i
- src_ready  out  1<<W_LOG  one-hot grant; block i consumed at posedge when src_valid[i] & src_ready[i]
- tree_emp  in  1<<W_LOG  per-way leaf-queue empty flags from tree
- tree_din  out  DATW<<P_LOG  block to tree
- tree_dinen  out  1  tree_din valid
- tree_din_idx  out  W_LOG  destination way of tree_din

## Operation
- eligible[i] = src_valid[i] & tree_emp[i] & (hold[i]==0) & ~STALL & ~RST.
- Pick: first eligible way scanning ptr, ptr+1, ... modulo 1<<W_LOG (wrap-around). src_ready = one-hot of pick, all-zero if none eligible. src_ready is combinational from current inputs/state; forced 0 while RST high.
- On grant g at posedge: tree_din <= src_data slice g; tree_din_idx <= g; tree_dinen <= 1; ptr <= g+1 (wraps W_LOG bits); hold[g] <= EMP_LAT.
- No grant: tree_dinen <= 0; tree_din, tree_din_idx hold last value; ptr unchanged.
- hold[i] (3-bit) decrements by 1 each cycle while nonzero; load on grant wins over decrement. Way i is ineligible while hold[i]!=0 regardless of tree_emp[i].
- Fairness: a continuously eligible way is granted within 1<<W_LOG grants.
- STALL high: no grant, holds still decrement, ptr unchanged.
- Source dropping src_valid without handshake is legal (no grant recorded).

## Timing
- Reset values: tree_dinen 0, tree_din 0, tree_din_idx 0, src_ready 0, ptr 0, all hold 0.
- RST asserted mid-operation: all state cleared asynchronously; a block in tree_din with tree_dinen high is dropped (tree is reset in the same domain).
- Grant to tree_dinen latency: exactly 1 cycle. Max throughput one block per cycle when distinct ways are eligible; same way at most once per EMP_LAT+1 cycles.
- All outputs except src_ready registered.

## Configuration
- WAY_FEED_CNT_EN defined: adds output feed_cnt (32 bits, reset 0), incremented on every tree_dinen cycle, wraps at 2^32; adds output stall_cnt (32 bits) counting cycles with STALL high and any src_valid&tree_emp set.
- Undefined: neither port nor counters exist; behaviour otherwise identical.

## Structure
- Shared package: way-count and block-width localparams derived from W_LOG/P_LOG/DATW, hold-counter width (3), packed-slice helper function.
- One sub-module: rr_pick — combinational rotate-priority encoder (inputs req vector, ptr; outputs one-hot grant, index, any). Arbiter registers, hold counters and output stage stay in way_feed_arbiter.

## Test plan (W_LOG=2, P_LOG=1, DATW=16, EMP_LAT=2)
- Reset: RST high 4 cycles with all src_valid=1 -> src_ready=0, tree_dinen=0, tree_din_idx=0 throughout; first grant after release is way 0.
- All 4 ways valid, tree_emp=4'b1111 permanent -> grants 0,1,2,3,0,... one per cycle; tree_din_idx sequence 0,1,2,3,0 each one cycle after its src_ready.
- Only way 2 valid, tree_emp[2] stuck 1 -> grants to way 2 at cycles t, t+3, t+6 (holdoff EMP_LAT=2).
- ptr=3, ways 1 and 3 eligible -> way 3 granted, then way 1 (wrap); ptr ends at 2.
- STALL high 3 cycles with all eligible -> no src_ready, tree_dinen 0; resumes at current ptr.
- RST pulsed while tree_dinen=1 for way 1 -> tree_dinen 0 immediately, ptr 0, holds 0; with WAY_FEED_CNT_EN, feed_cnt returns to 0.
